// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the fetch program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_RST    = 2'd0,
    ST_FETCH  = 2'd1,
    ST_BUBBLE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_RST   = 3'd0,
    SRC_FLUSH = 3'd1,
    SRC_BR    = 3'd2,
    SRC_RAS   = 3'd3,
    SRC_SEQ   = 3'd4,
    SRC_HOLD  = 3'd5
  } src_e;

  // INC is a power of two, so ~(INC-1) clears exactly the low log2(INC) bits.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    logic [63:0] mask_v;
    mask_v = ~(64'(inc) - 64'd1);
    return mask_v;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Fetch-request channel between the PC generator and instruction memory.
interface pc_gen_if #(
  parameter int PC_W = 32
);
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] pc_plus_o;
  logic            pc_valid_o;
  logic            pc_ready_i;

  modport master (output pc_o, output pc_plus_o, output pc_valid_o, input pc_ready_i);
  modport slave  (input pc_o, input pc_plus_o, input pc_valid_o, output pc_ready_i);
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; when full, a push overwrites the oldest entry.
module pc_ras #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] data_i,
  output logic [PC_W-1:0] top_o,
  output logic            empty_o,
  output logic            full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PC_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] top_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] top_inc_s;
  logic [PTR_W-1:0] top_dec_s;

  assign top_inc_s = top_r + PTR_W'(1);
  assign top_dec_s = top_r - PTR_W'(1);
  assign top_o     = mem_r[top_r];
  assign empty_o   = (cnt_r == CNT_W'(0));
  assign full_o    = (cnt_r == CNT_W'(DEPTH));

  // Stack storage, top pointer and occupancy; push+pop together replaces the top.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_r <= PTR_W'(0);
      cnt_r <= CNT_W'(0);
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {PC_W{1'b0}};
      end
    end else if (push_i && pop_i) begin
      mem_r[top_r] <= data_i;
    end else if (push_i) begin
      mem_r[top_inc_s] <= data_i;
      top_r            <= top_inc_s;
      if (!full_o) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end else if (pop_i) begin
      top_r <= top_dec_s;
      cnt_r <= cnt_r - CNT_W'(1);
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: prioritised redirect mux, fetch FSM and RAS return prediction.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [PC_W-1:0] flush_pc_i,
  input  logic            br_taken_i,
  input  logic [PC_W-1:0] br_target_i,
  input  logic            call_i,
  input  logic            ret_i,
  pc_gen_if.master        fetch,
  output logic            ras_empty_o,
  output logic            ras_full_o
);
  localparam logic [63:0]     MASK_FULL  = align_mask(INC);
  localparam logic [PC_W-1:0] ALIGN_MASK = MASK_FULL[PC_W-1:0];

  state_e          state_r;
  state_e          state_nxt_s;
  src_e            src_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_nxt_s;
  logic [PC_W-1:0] pc_plus_s;
  logic [PC_W-1:0] ras_top_s;
  logic            fire_s;
  logic            ras_op_s;
  logic            push_s;
  logic            pop_s;

  assign pc_plus_s        = pc_r + PC_W'(INC);
  assign fetch.pc_o       = pc_r;
  assign fetch.pc_plus_o  = pc_plus_s;
  assign fetch.pc_valid_o = (state_r == ST_FETCH);

  // Handshake, next-PC source selection, PC mux and FSM next state.
  always_comb begin
    fire_s      = 1'b0;
    src_s       = SRC_HOLD;
    pc_nxt_s    = pc_r;
    state_nxt_s = state_r;

    fire_s = fetch.pc_valid_o & fetch.pc_ready_i & ~stall_i;

    if (rst_i) begin
      src_s = SRC_RST;
    end else if (flush_i) begin
      src_s = SRC_FLUSH;
    end else if (br_taken_i) begin
      src_s = SRC_BR;
    end else if (fire_s && ret_i && !ras_empty_o) begin
      src_s = SRC_RAS;
    end else if (fire_s) begin
      src_s = SRC_SEQ;
    end else begin
      src_s = SRC_HOLD;
    end

    case (src_s)
      SRC_RST:   pc_nxt_s = RESET_PC;
      SRC_FLUSH: pc_nxt_s = flush_pc_i & ALIGN_MASK;
      SRC_BR:    pc_nxt_s = br_target_i & ALIGN_MASK;
      SRC_RAS:   pc_nxt_s = ras_top_s;
      SRC_SEQ:   pc_nxt_s = pc_plus_s;
      SRC_HOLD:  pc_nxt_s = pc_r;
      default:   pc_nxt_s = pc_r;
    endcase

    // Any flush costs exactly one invalid cycle; a repeated flush extends it.
    case (state_r)
      ST_RST:    state_nxt_s = flush_i ? ST_BUBBLE : ST_FETCH;
      ST_FETCH:  state_nxt_s = flush_i ? ST_BUBBLE : ST_FETCH;
      ST_BUBBLE: state_nxt_s = flush_i ? ST_BUBBLE : ST_FETCH;
      default:   state_nxt_s = ST_RST;
    endcase
  end

  // PC register and FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= ST_RST;
      pc_r    <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Redirects and reset suppress RAS updates; a return on an empty stack is dropped.
  assign ras_op_s = fire_s & ~flush_i & ~br_taken_i & ~rst_i;
  assign push_s   = ras_op_s & call_i;
  assign pop_s    = ras_op_s & ret_i & ~ras_empty_o;

  pc_ras #(
    .PC_W  (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (pc_plus_s & ALIGN_MASK),
    .top_o   (ras_top_s),
    .empty_o (ras_empty_o),
    .full_o  (ras_full_o)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Directed scoreboard bench for pc_gen: a 32-bit instance and an 8-bit wrap instance.
module tb_pc_gen;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: PC_W=32, RESET_PC=0x100, INC=4, RAS_DEPTH=4
  logic        rst_a, stall_a, flush_a, br_a, call_a, ret_a;
  logic [31:0] fpc_a, bt_a;
  logic        empty_a, full_a;
  pc_gen_if #(.PC_W(32)) if_a ();

  pc_gen #(.PC_W(32), .RESET_PC(32'h100), .INC(4), .RAS_DEPTH(4)) dut_a (
    .clk_i(clk), .rst_i(rst_a), .stall_i(stall_a), .flush_i(flush_a),
    .flush_pc_i(fpc_a), .br_taken_i(br_a), .br_target_i(bt_a),
    .call_i(call_a), .ret_i(ret_a), .fetch(if_a.master),
    .ras_empty_o(empty_a), .ras_full_o(full_a));

  // Instance B: PC_W=8, RESET_PC=0xF8, INC=4, RAS_DEPTH=2
  logic       rst_b;
  logic       empty_b, full_b;
  pc_gen_if #(.PC_W(8)) if_b ();

  pc_gen #(.PC_W(8), .RESET_PC(8'hF8), .INC(4), .RAS_DEPTH(2)) dut_b (
    .clk_i(clk), .rst_i(rst_b), .stall_i(1'b0), .flush_i(1'b0),
    .flush_pc_i(8'h00), .br_taken_i(1'b0), .br_target_i(8'h00),
    .call_i(1'b0), .ret_i(1'b0), .fetch(if_b.master),
    .ras_empty_o(empty_b), .ras_full_o(full_b));

  typedef struct {
    string       tag;
    bit          is_b;
    logic [31:0] pc;
    logic        valid;
    logic        empty;
    logic        full;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
  endtask

  task automatic drv(input logic rst, input logic stall, input logic flush, input logic [31:0] fpc,
                     input logic br, input logic [31:0] bt, input logic call, input logic ret,
                     input logic ready);
    rst_a = rst; stall_a = stall; flush_a = flush; fpc_a = fpc;
    br_a = br; bt_a = bt; call_a = call; ret_a = ret; if_a.pc_ready_i = ready;
  endtask

  // Advance one clock, then pop every queued expectation against the DUT outputs.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (!e.is_b) begin
        chk({e.tag, ".pc"},    if_a.pc_o,              e.pc);
        chk({e.tag, ".plus"},  if_a.pc_plus_o,         e.pc + 32'h4);
        chk({e.tag, ".valid"}, {31'd0, if_a.pc_valid_o}, {31'd0, e.valid});
        chk({e.tag, ".empty"}, {31'd0, empty_a},       {31'd0, e.empty});
        chk({e.tag, ".full"},  {31'd0, full_a},        {31'd0, e.full});
      end else begin
        chk({e.tag, ".pc"},    {24'd0, if_b.pc_o},      e.pc);
        chk({e.tag, ".plus"},  {24'd0, if_b.pc_plus_o}, (e.pc + 32'h4) & 32'hFF);
        chk({e.tag, ".valid"}, {31'd0, if_b.pc_valid_o}, {31'd0, e.valid});
      end
    end
  endtask

  task automatic step_a(input string tag, input logic [31:0] pc, input logic v,
                        input logic e, input logic f);
    sb.push_back('{tag: tag, is_b: 1'b0, pc: pc, valid: v, empty: e, full: f});
    tick();
  endtask

  task automatic step_b(input string tag, input logic [31:0] pc, input logic v);
    sb.push_back('{tag: tag, is_b: 1'b1, pc: pc, valid: v, empty: 1'b1, full: 1'b0});
    tick();
  endtask

  initial begin
    rst_b = 1'b1;
    if_b.pc_ready_i = 1'b1;
    drv(1, 0, 0, 0, 0, 0, 0, 0, 1);
    step_a("rst", 32'h100, 0, 1, 0);
    step_a("rst2", 32'h100, 0, 1, 0);

    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step_a("first", 32'h100, 1, 1, 0);
    step_a("seq1", 32'h104, 1, 1, 0);
    step_a("seq2", 32'h108, 1, 1, 0);

    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step_a("notready", 32'h108, 1, 1, 0);
    drv(0, 1, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step_a("stall", 32'h108, 1, 1, 0);

    // Flush beats branch and suppresses the call push
    drv(0, 0, 1, 32'h400, 1, 32'h200, 1, 0, 1);
    step_a("flush", 32'h400, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step_a("bubble_end", 32'h400, 1, 1, 0);
    step_a("post_flush", 32'h404, 1, 1, 0);
    drv(0, 0, 0, 0, 1, 32'h203, 0, 0, 1);
    step_a("branch_align", 32'h200, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step_a("post_branch", 32'h204, 1, 1, 0);

    // Five calls at 0x10..0x50; the fifth overwrites the oldest entry
    for (int k = 1; k <= 5; k++) begin
      drv(0, 0, 0, 0, 1, 32'h10 * k, 0, 0, 1);
      step_a("br_to_call", 32'h10 * k, 1, (k == 1), (k == 5));
      drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
      step_a("call", 32'h10 * k + 32'h4, 1, 0, (k >= 4));
    end

    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step_a("ret1", 32'h54, 1, 0, 0);
    step_a("ret2", 32'h44, 1, 0, 0);
    step_a("ret3", 32'h34, 1, 0, 0);
    step_a("ret4", 32'h24, 1, 1, 0);
    step_a("ret_empty", 32'h28, 1, 1, 0);

    // Call+return swaps the top entry
    drv(0, 0, 0, 0, 1, 32'h20, 0, 0, 1);
    step_a("br20", 32'h20, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step_a("call20", 32'h24, 1, 0, 0);
    drv(0, 0, 0, 0, 1, 32'h80, 0, 0, 1);
    step_a("br80", 32'h80, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 1, 1);
    step_a("callret", 32'h24, 1, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step_a("ret_new_top", 32'h84, 1, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 1, 0, 1);
    step_a("call84", 32'h88, 1, 0, 0);

    // Reset mid-stream wins over branch and call
    drv(1, 0, 0, 0, 1, 32'h300, 1, 0, 1);
    step_a("mid_rst", 32'h100, 0, 1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step_a("mid_rst_rel", 32'h100, 1, 1, 0);

    // 8-bit wrap-around
    step_b("b_rst", 32'hF8, 0);
    rst_b = 1'b0;
    step_b("b_first", 32'hF8, 1);
    step_b("b_fc", 32'hFC, 1);
    step_b("b_wrap", 32'h00, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch program-counter generator: the next generation of our 13-bit PC register. It adds configurable width, reset vector and increment, a valid/ready handshake to instruction memory, and prioritised flush and branch redirects. It also includes a small return-address stack (RAS) that predicts return targets. It sits at the head of the fetch stage, drives the instruction-memory address, and takes redirects from decode/execute.

## Interface
- PC_W, 32, PC and address width in bits (≥ 8)
- RESET_PC, 0, PC value loaded by reset (PC_W bits)
- INC, 4, sequential increment; power of two, 1..8
- RAS_DEPTH, 4, RAS entries; power of two, ≥ 2
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, synchronous, active-high
- stall_i  in  1  hold the PC; block sequential advance and RAS ops
- flush_i  in  1  trap/mispredict redirect, highest priority
- flush_pc_i  in  PC_W  flush target
- br_taken_i  in  1  resolved-taken branch redirect
- br_target_i  in  PC_W  branch target
- call_i  in  1  the fetched instruction at pc_o is a call; push on fire
- ret_i  in  1  the fetched instruction at pc_o is a return; pop/predict on fire
- pc_ready_i  in  1  instruction memory accepts pc_o
- pc_o  out  PC_W  current fetch PC
- pc_plus_o  out  PC_W  pc_o + INC, mod 2^PC_W
- pc_valid_o  out  1  pc_o is a valid fetch request
- ras_empty_o  out  1  RAS holds 0 entries
- ras_full_o  out  1  RAS holds RAS_DEPTH entries

## Operation
- **fire** = pc_valid_o & pc_ready_i & !stall_i.
- **Next-PC priority** (one source per cycle):
  - rst_i: RESET_PC
  - flush_i: flush_pc_i
  - br_taken_i: br_target_i
  - fire & ret_i & !ras_empty_o: RAS top
  - fire: pc_plus_o
  - otherwise: hold
- **Target alignment:** the low log2(INC) bits of flush_pc_i, br_target_i and pushed RAS values are forced to 0.
- **Wrap-around:** pc_plus_o wraps modulo 2^PC_W, with no flag.
- **Redirect vs. handshake:** flush and branch redirects apply whether or not the handshake completes, and also apply while stall_i is high.
- **FSM states:** RST, FETCH, BUBBLE.
  - RST is entered on rst_i. pc_valid_o = 0. Goes to FETCH next cycle.
  - FETCH: pc_valid_o = 1. A flush_i goes to BUBBLE. A branch stays in FETCH (no bubble).
  - BUBBLE: pc_valid_o = 0 for exactly one cycle, then FETCH. A flush_i arriving in BUBBLE reloads the PC and stays in BUBBLE one more cycle.
- **RAS behaviour** (only on fire, and only when neither flush_i nor br_taken_i is asserted):
  - call_i alone: push pc_plus_o. When full, overwrite the oldest entry (circular); count stays RAS_DEPTH and ras_full_o stays 1.
  - ret_i alone: pop. next PC = popped value. When empty, ret_i is ignored and the PC advances sequentially.
  - call_i & ret_i: next PC = old top. The top entry is replaced by pc_plus_o; count unchanged. When empty, this acts as a plain push.
- flush_i does not modify RAS contents.
- **Reset:** pc_o = RESET_PC, pc_plus_o = RESET_PC + INC, pc_valid_o = 0, RAS count 0, ras_empty_o = 1, ras_full_o = 0. Reset mid-operation discards any redirect and RAS op in that cycle.

## Timing
- All outputs are registered or derived combinationally from registered state. No combinational path from any input to pc_o, pc_valid_o or the RAS flags.
- Redirect latency is 1 cycle: a target sampled at edge N appears on pc_o after edge N.
- Without stalls, a new PC is presented every cycle while pc_ready_i is high.
- pc_o stays stable while pc_valid_o & !pc_ready_i.
- First valid fetch appears 1 cycle after rst_i deasserts.
- A flush costs 1 bubble cycle. A branch costs 0.

## Structure
- Package **pc_gen_pkg** holds:
  - the FSM state enum (ST_RST, ST_FETCH, ST_BUBBLE)
  - the next-PC source enum (SRC_RST, SRC_FLUSH, SRC_BR, SRC_RAS, SRC_SEQ, SRC_HOLD)
  - the alignment-mask function
- One sub-module, **pc_ras**: a circular stack with RAS_DEPTH entries, a top pointer and a count. Inputs are push/pop/data; outputs are top, empty and full.
- The top level holds the FSM, the next-PC mux, the PC register and the adder.

## Test plan
- Reset with PC_W=32, RESET_PC=0x100, INC=4, ready high: after release, pc_o = 0x100, 0x104, 0x108 on consecutive cycles; pc_valid_o = 0 during reset.
- Hold pc_ready_i low 3 cycles at pc_o = 0x108: pc_o holds 0x108. Same with stall_i high instead: pc_o holds.
- In one cycle assert flush_i (0x400), br_taken_i (0x200) and call_i: pc_o = 0x400, pc_valid_o = 0 for one cycle, RAS unchanged. A branch alone to 0x203 gives pc_o = 0x200 with no bubble.
- RAS_DEPTH=4: five calls at 0x10, 0x20, 0x30, 0x40, 0x50 give ras_full_o = 1 throughout the fifth. Four returns yield 0x54, 0x44, 0x34, 0x24. ras_empty_o = 1 after the fourth; a fifth return advances sequentially.
- Simultaneous call and return with top = 0x24 at pc_o = 0x80: next pc_o = 0x24, new top = 0x84.
- PC_W=8, pc_o = 0xFC, INC=4: next pc_o = 0x00. Assert rst_i mid-stream together with br_taken_i: pc_o = RESET_PC, RAS empty.
